multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, width of ALU_CONTROL; SHALL be at least 3.
REQ-002 Parameter WAIT_MEM, default 1; 1 means memory-access states wait for MEM_READY, 0 means MEM_READY is ignored and treated as 1.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST_N  in  1  synchronous, active-low reset.
REQ-005 OP  in  7  opcode of the instruction register; FUNCT_3 in 3; FUNCT_7_5 in 1.
REQ-006 ZERO  in  1  ALU zero flag; LT in 1 signed-less-than flag; LTU in 1 unsigned-less-than flag.
REQ-007 MEM_READY  in  1  memory has completed the current access this cycle.
REQ-008 PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE  out  1 each  datapath enables and selects.
REQ-009 RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC  out  2 each; ALU_CONTROL  out  ALU_CTRL_W.
REQ-010 ILLEGAL  out  1  sticky undecodable-opcode flag; RETIRE  out  1  one-cycle pulse per completed instruction.

Function
REQ-011 FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL and HALT.
REQ-012 FETCH: ADR_SRC=0, ALU_SRC_A=00 (PC), ALU_SRC_B=10 (+4), ALU add, RESULT_SRC=10. IR_WRITE and PC_WRITE assert only in the cycle MEM_READY=1, which is also the cycle the FSM moves to DECODE.
REQ-013 DECODE: ALU_SRC_A=01 (old PC), ALU_SRC_B=01 (imm), IMM_SRC=10, ALU add.
REQ-013a DECODE next state by OP: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; any other OP -> HALT.
REQ-014 MEMADR: ALU_SRC_A=10, ALU_SRC_B=01, IMM_SRC=00 for load or 01 for store, ALU add; next state MEMREAD for OP[5]=0, MEMWRITE for OP[5]=1.
REQ-015 MEMREAD: ADR_SRC=1, RESULT_SRC=00; holds until MEM_READY=1, then goes to MEMWB.
REQ-015a MEMWB: RESULT_SRC=01, REG_WRITE=1, RETIRE=1; next state FETCH.
REQ-016 MEMWRITE: ADR_SRC=1, RESULT_SRC=00, MEM_WRITE=1 every cycle until MEM_READY=1; RETIRE=1 in that cycle; next state FETCH.
REQ-017 EXECUTER: ALU_SRC_A=10, ALU_SRC_B=00. EXECUTEI: ALU_SRC_B=01, IMM_SRC=00. Both go to ALUWB.
REQ-017a ALUWB: RESULT_SRC=00, REG_WRITE=1, RETIRE=1; next state FETCH.
REQ-018 ALU decode, zero-extended to ALU_CTRL_W: add 000, sub 001, and 010, or 011, slt 101. FUNCT_3=000 with OP[5]&FUNCT_7_5=1 gives sub.
REQ-019 BRANCH: ALU_SRC_A=10, ALU_SRC_B=00, sub, RESULT_SRC=00. PC_WRITE=take, where beq take=ZERO. RETIRE=1; next state FETCH.
REQ-020 JAL: ALU_SRC_A=01, ALU_SRC_B=10, add, RESULT_SRC=00, PC_WRITE=1; next state ALUWB, which asserts RETIRE.
REQ-021 HALT: ILLEGAL=1, all enables 0; the FSM stays in HALT until reset.
REQ-022 Outputs SHALL be a combinational function of state and inputs only. Every enable not listed for a state SHALL be 0.
REQ-023 In a waiting state with MEM_READY=0, outputs SHALL stay stable and no register write SHALL occur.

Reset
REQ-024 RST_N=0 at a rising edge SHALL force state FETCH, including mid-instruction and from HALT, and clear ILLEGAL.
REQ-025 While RST_N=0, every enable output SHALL be 0 and RETIRE SHALL be 0.

Configuration
REQ-026 Macro BRANCH_EXT_EN defined: BRANCH SHALL take bne (001)=!ZERO, blt (100)=LT, bge (101)=!LT, bltu (110)=LTU, bgeu (111)=!LTU.
REQ-026a BRANCH_EXT_EN defined: FUNCT_3 010 or 011 in DECODE for a branch SHALL go to HALT.
REQ-027 Macro BRANCH_EXT_EN undefined: only beq is decoded, and any branch FUNCT_3 is treated as beq; LT and LTU are unused.

Structure
REQ-028 A shared package SHALL hold the state enum and the localparams for the ALU_CONTROL, ALU_SRC_A/B, RESULT_SRC and IMM_SRC encodings.
REQ-029 The ALU decode SHALL be one sub-module, alu_decoder_v2; the FSM and branch-condition logic stay in the top.

Verification
REQ-030 add x3,x1,x2 (OP=0110011, FUNCT_3=000, FUNCT_7_5=0), MEM_READY=1: states FETCH, DECODE, EXECUTER, ALUWB; REG_WRITE=1 and RETIRE=1 in cycle 4.
REQ-031 lw with MEM_READY low for 3 cycles in MEMREAD: FSM holds MEMREAD for 4 cycles with REG_WRITE=0, then MEMWB writes.
REQ-032 sw with MEM_READY low 2 cycles: MEM_WRITE=1 for 3 consecutive cycles, RETIRE=1 only in the last.
REQ-033 BRANCH_EXT_EN defined, bne with ZERO=1: PC_WRITE=0. Same with ZERO=0: PC_WRITE=1.
REQ-034 OP=1111111: DECODE goes to HALT, ILLEGAL=1 held for 10 cycles; RST_N=0 for one edge returns the FSM to FETCH with ILLEGAL=0.
REQ-035 RST_N asserted during MEMWRITE wait: next state FETCH, MEM_WRITE=0 in that cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM state codes, ALU
// control codes, ALU decoder operation classes, datapath mux selects and
// the opcodes the controller recognises.
package multicycle_controller_pkg;

  // FSM state codes
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  // ALU_CONTROL codes (zero-extended to the top-level width)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU_SRC_A selects
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;

  // ALU_SRC_B selects
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // RESULT_SRC selects
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  // IMM_SRC selects
  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;

  // Recognised opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder (module alu_decoder_v2): maps the FSM's operation class and
// the instruction function fields onto an ALU_CONTROL code. ALU_CTRL_W must
// be at least 3; the 3-bit code is zero-extended to that width.
module alu_decoder_v2
  import multicycle_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct_3_i,
  input  logic                  funct_7_5_i,
  input  logic                  op_5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o
);

  logic [2:0] ctrl;

  // Pick the ALU operation; only register-register ops can request sub via funct7
  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB:   ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_3_i)
          3'b000:  ctrl = (op_5_i & funct_7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl = ALU_SLT;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ADD;
        endcase
      end
      default:     ctrl = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style controller: sequencing FSM, branch condition and
// datapath control outputs. Outputs are combinational in state and inputs.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu; without it every
// branch is evaluated as beq.
//
// state      | meaning
// FETCH      | read instruction, PC+4; IR/PC written when memory is ready
// DECODE     | register read, branch target PC+imm computed
// MEMADR     | load/store address = rs1 + imm
// MEMREAD    | load data access, waits for memory
// MEMWB      | write loaded data to register file
// MEMWRITE   | store data access, waits for memory
// EXECUTER   | register-register ALU op
// EXECUTEI   | register-immediate ALU op
// ALUWB      | write ALU result to register file
// BRANCH     | compare rs1/rs2, load target into PC if taken
// JAL        | PC <= target, link value PC+4 computed
// HALT       | undecodable opcode, parked until reset
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int WAIT_MEM   = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [6:0]            OP,
  input  logic [2:0]            FUNCT_3,
  input  logic                  FUNCT_7_5,
  input  logic                  ZERO,
  input  logic                  LT,
  input  logic                  LTU,
  input  logic                  MEM_READY,
  output logic                  PC_WRITE,
  output logic                  ADR_SRC,
  output logic                  MEM_WRITE,
  output logic                  IR_WRITE,
  output logic                  REG_WRITE,
  output logic [1:0]            RESULT_SRC,
  output logic [1:0]            ALU_SRC_A,
  output logic [1:0]            ALU_SRC_B,
  output logic [1:0]            IMM_SRC,
  output logic [ALU_CTRL_W-1:0] ALU_CONTROL,
  output logic                  ILLEGAL,
  output logic                  RETIRE
);

  logic [3:0] state_q, state_d;
  logic       mem_rdy;
  logic       take;
  logic       pc_write, mem_write, ir_write, reg_write, retire;
  logic [1:0] alu_op;

  assign mem_rdy = (WAIT_MEM != 0) ? MEM_READY : 1'b1;

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef BRANCH_EXT_EN
  // Branch condition from funct3; 010/011 never reach BRANCH (decoded to HALT)
  always_comb begin
    case (FUNCT_3)
      3'b000:  take = ZERO;
      3'b001:  take = ~ZERO;
      3'b100:  take = LT;
      3'b101:  take = ~LT;
      3'b110:  take = LTU;
      3'b111:  take = ~LTU;
      default: take = 1'b0;
    endcase
  end
`else
  // Only beq is supported; any branch funct3 compares for equality
  always_comb begin
    take = ZERO;
  end

  logic lt_flags_unused;
  assign lt_flags_unused = LT ^ LTU;
`endif

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    ADR_SRC    = 1'b0;
    RESULT_SRC = RES_ALUOUT;
    ALU_SRC_A  = SRCA_PC;
    ALU_SRC_B  = SRCB_RD2;
    IMM_SRC    = IMM_I;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALU_SRC_B  = SRCB_FOUR;
        RESULT_SRC = RES_ALURES;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_IMM;
        IMM_SRC   = IMM_B;
        case (OP)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH: begin
`ifdef BRANCH_EXT_EN
            if (FUNCT_3 == 3'b010 || FUNCT_3 == 3'b011) state_d = S_HALT;
            else                                          state_d = S_BRANCH;
`else
            state_d = S_BRANCH;
`endif
          end
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_IMM;
        IMM_SRC   = OP[5] ? IMM_S : IMM_I;
        state_d   = OP[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ADR_SRC = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RESULT_SRC = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        ADR_SRC   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_IMM;
        IMM_SRC   = IMM_I;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        pc_write  = take;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Enables are forced low while reset is held so nothing commits mid-reset
  assign PC_WRITE  = RST_N & pc_write;
  assign MEM_WRITE = RST_N & mem_write;
  assign IR_WRITE  = RST_N & ir_write;
  assign REG_WRITE = RST_N & reg_write;
  assign RETIRE    = RST_N & retire;

  // HALT is only left through reset, so decoding the state makes the flag sticky
  assign ILLEGAL = (state_q == S_HALT);

  alu_decoder_v2 #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_3_i     (FUNCT_3),
    .funct_7_5_i   (FUNCT_7_5),
    .op_5_i        (OP[5]),
    .alu_control_o (ALU_CONTROL)
  );

endmodule
